// File: rtl/uart_xmt_fifo.sv
// UART transmitter with an input word FIFO: queued words are sent back-to-back as
// start / data (LSB first) / optional parity / 1-2 stop frames.
module uart_xmt_fifo #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [WORD_SIZE-1:0] i_data_bus,
  input  logic                 i_load_xmt_data,
  input  logic                 i_enable,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_two_stop,
  output logic                 o_serial_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_fifo_full,
  output logic                 o_fifo_empty,
  output logic [CNT_W-1:0]     o_fifo_count,
  output logic                 o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WORD_SIZE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state, next_state;

  logic [WORD_SIZE-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 overflow_q;

  logic [WORD_SIZE-1:0] shift_reg;
  logic [CLK_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 par_bit, par_en_q, two_stop_q, done_q;

  logic fifo_full, fifo_empty, bit_tick, last_data, last_stop, frame_end, pop, push_ok;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign bit_tick   = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));
  assign last_data  = (bit_idx == IDX_W'(WORD_SIZE - 1));
  assign last_stop  = (bit_idx == (two_stop_q ? IDX_W'(1) : '0));
  assign frame_end  = (state == STOP) && bit_tick && last_stop;

  // A pop happens from IDLE or on the final stop edge, which gives gap-free chaining.
  assign pop     = !fifo_empty && i_enable && ((state == IDLE) || frame_end);
  assign push_ok = i_load_xmt_data && (!fifo_full || pop);

  always_ff @(posedge i_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= i_data_bus;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (i_load_xmt_data && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pop) next_state = START;
      START:   if (bit_tick) next_state = DATA;
      DATA:    if (bit_tick && last_data) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_tick) next_state = STOP;
      STOP:    if (frame_end) next_state = pop ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame configuration and parity are captured at pop time so mid-frame input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_reg  <= '0;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      par_bit    <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (pop) begin
        shift_reg  <= fifo_mem[rd_ptr];
        par_bit    <= (^fifo_mem[rd_ptr]) ^ (i_parity_mode == 2'b10);
        par_en_q   <= (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
        two_stop_q <= i_two_stop;
        clk_cnt    <= '0;
        bit_idx    <= '0;
      end else if (state != IDLE) begin
        if (bit_tick) begin
          clk_cnt <= '0;
          case (state)
            DATA: begin
              shift_reg <= shift_reg >> 1;
              bit_idx   <= last_data ? '0 : bit_idx + IDX_W'(1);
            end
            STOP:    bit_idx <= last_stop ? '0 : bit_idx + IDX_W'(1);
            default: bit_idx <= bit_idx;
          endcase
        end else begin
          clk_cnt <= clk_cnt + CLK_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_serial_out = 1'b1;
    case (state)
      START:   o_serial_out = 1'b0;
      DATA:    o_serial_out = shift_reg[0];
      PARITY:  o_serial_out = par_bit;
      default: o_serial_out = 1'b1;
    endcase
  end

  assign o_busy       = (state != IDLE);
  assign o_done       = done_q;
  assign o_fifo_full  = fifo_full;
  assign o_fifo_empty = fifo_empty;
  assign o_fifo_count = count;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_uart_xmt_fifo.sv
// Randomised and directed bench for uart_xmt_fifo; a queue-based model predicts the
// expected line waveform and FIFO status every cycle.
module tb_uart_xmt_fifo;

  localparam int WORD_SIZE    = 8;
  localparam int CLKS_PER_BIT = 4;
  localparam int FIFO_DEPTH   = 4;
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic [WORD_SIZE-1:0] i_data_bus = '0;
  logic                 i_load_xmt_data = 1'b0;
  logic                 i_enable = 1'b0;
  logic [1:0]           i_parity_mode = 2'b00;
  logic                 i_two_stop = 1'b0;
  logic                 o_serial_out, o_busy, o_done, o_fifo_full, o_fifo_empty, o_overflow;
  logic [CNT_W-1:0]     o_fifo_count;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int busy_cycles = 0;

  // Model: queued words plus the remaining per-cycle line values of the frame in flight.
  logic [WORD_SIZE-1:0] m_fifo [$];
  bit                   m_line [$];
  bit                   m_done = 1'b0;
  bit                   m_ovf = 1'b0;

  uart_xmt_fifo #(
    .WORD_SIZE(WORD_SIZE), .CLKS_PER_BIT(CLKS_PER_BIT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data_bus(i_data_bus),
    .i_load_xmt_data(i_load_xmt_data), .i_enable(i_enable),
    .i_parity_mode(i_parity_mode), .i_two_stop(i_two_stop),
    .o_serial_out(o_serial_out), .o_busy(o_busy), .o_done(o_done),
    .o_fifo_full(o_fifo_full), .o_fifo_empty(o_fifo_empty),
    .o_fifo_count(o_fifo_count), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void buildFrame(input logic [WORD_SIZE-1:0] w, input logic [1:0] mode, input bit two);
    for (int c = 0; c < CLKS_PER_BIT; c++) m_line.push_back(1'b0);
    for (int i = 0; i < WORD_SIZE; i++)
      for (int c = 0; c < CLKS_PER_BIT; c++) m_line.push_back(w[i]);
    if (mode == 2'b01 || mode == 2'b10)
      for (int c = 0; c < CLKS_PER_BIT; c++) m_line.push_back((^w) ^ (mode == 2'b10));
    for (int c = 0; c < (two ? 2 : 1) * CLKS_PER_BIT; c++) m_line.push_back(1'b1);
  endfunction

  task automatic modelEdge();
    bit ending, free, do_pop, push_ok;
    logic [WORD_SIZE-1:0] w;
    if (i_reset) begin
      m_fifo.delete();
      m_line.delete();
      m_done = 1'b0;
      m_ovf  = 1'b0;
      return;
    end
    ending = (m_line.size() == 1);
    free   = (m_line.size() <= 1);
    if (m_line.size() > 0) m_line.delete(0);
    m_done  = ending;
    do_pop  = (m_fifo.size() > 0) && i_enable && free;
    push_ok = i_load_xmt_data && ((m_fifo.size() < FIFO_DEPTH) || do_pop);
    if (do_pop) begin
      w = m_fifo.pop_front();
      buildFrame(w, i_parity_mode, i_two_stop);
    end
    if (push_ok) m_fifo.push_back(i_data_bus);
    else if (i_load_xmt_data) m_ovf = 1'b1;
  endtask

  task automatic step();
    @(posedge i_clk);
    modelEdge();
    #1;
    checkOutput("serial", 32'(o_serial_out), 32'(m_line.size() > 0 ? m_line[0] : 1'b1));
    checkOutput("busy", 32'(o_busy), 32'(m_line.size() > 0));
    checkOutput("done", 32'(o_done), 32'(m_done));
    checkOutput("count", 32'(o_fifo_count), 32'(m_fifo.size()));
    checkOutput("full", 32'(o_fifo_full), 32'(m_fifo.size() == FIFO_DEPTH));
    checkOutput("empty", 32'(o_fifo_empty), 32'(m_fifo.size() == 0));
    checkOutput("overflow", 32'(o_overflow), 32'(m_ovf));
    if (o_done) done_seen++;
    if (o_busy) busy_cycles++;
  endtask

  task automatic applyStimulus(input bit load, input logic [WORD_SIZE-1:0] data, input bit en,
                               input logic [1:0] mode, input bit two);
    i_load_xmt_data = load;
    i_data_bus      = data;
    i_enable        = en;
    i_parity_mode   = mode;
    i_two_stop      = two;
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b0);
    step();
    step();
    i_reset = 1'b0;
  endtask

  task automatic singleFrame(input logic [1:0] mode, input bit two, input int exp_len, input string tag);
    done_seen = 0;
    busy_cycles = 0;
    applyStimulus(1'b1, 8'hA5, 1'b1, mode, two);
    step();
    checkOutput({tag, "_lat_k"}, 32'(o_serial_out), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, mode, two);
    step();
    checkOutput({tag, "_lat_k1"}, 32'(o_serial_out), 32'd0);
    repeat (60) step();
    checkOutput({tag, "_len"}, 32'(busy_cycles), 32'(exp_len));
    checkOutput({tag, "_dones"}, 32'(done_seen), 32'd1);
    checkOutput({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int guard;
    doReset();
    checkOutput("rst_serial", 32'(o_serial_out), 32'd1);
    checkOutput("rst_empty", 32'(o_fifo_empty), 32'd1);

    // Single frames: plain, even parity + two stops, odd parity + two stops.
    singleFrame(2'b00, 1'b0, 40, "plain");
    singleFrame(2'b01, 1'b1, 48, "even");
    singleFrame(2'b10, 1'b1, 48, "odd");

    // Fill with enable low, overflow on the fifth push, then drain back-to-back.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 2'b00, 1'b0);
      step();
    end
    checkOutput("fill_full", 32'(o_fifo_full), 32'd1);
    checkOutput("fill_ovf", 32'(o_overflow), 32'd1);
    done_seen = 0;
    busy_cycles = 0;
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b00, 1'b0);
    repeat (180) step();
    checkOutput("drain_dones", 32'(done_seen), 32'd4);
    checkOutput("drain_busy", 32'(busy_cycles), 32'd160);

    // Full FIFO with a push landing on the frame-end pop edge.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 2'b00, 1'b0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b00, 1'b0);
    step();
    applyStimulus(1'b1, 8'h14, 1'b1, 2'b00, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b00, 1'b0);
    guard = 0;
    while (m_line.size() != 1 && guard < 100) begin
      step();
      guard++;
    end
    checkOutput("fe_reached", 32'(guard < 100), 32'd1);
    applyStimulus(1'b1, 8'h15, 1'b1, 2'b00, 1'b0);
    step();
    checkOutput("simul_count", 32'(o_fifo_count), 32'd4);
    checkOutput("simul_ovf", 32'(o_overflow), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b00, 1'b0);
    repeat (220) step();

    // Reset during data bit 3 of 0x3C with two words still queued.
    doReset();
    applyStimulus(1'b1, 8'h3C, 1'b0, 2'b00, 1'b0); step();
    applyStimulus(1'b1, 8'h11, 1'b0, 2'b00, 1'b0); step();
    applyStimulus(1'b1, 8'h22, 1'b0, 2'b00, 1'b0); step();
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b00, 1'b0); step();
    repeat (17) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    checkOutput("midrst_serial", 32'(o_serial_out), 32'd1);
    checkOutput("midrst_count", 32'(o_fifo_count), 32'd0);
    checkOutput("midrst_busy", 32'(o_busy), 32'd0);
    busy_cycles = 0;
    repeat (30) step();
    checkOutput("midrst_quiet", 32'(busy_cycles), 32'd0);

    // Parity mode change mid-frame only affects the following frame.
    busy_cycles = 0;
    done_seen = 0;
    applyStimulus(1'b1, 8'h5A, 1'b1, 2'b00, 1'b0); step();
    applyStimulus(1'b1, 8'hC3, 1'b1, 2'b00, 1'b0); step();
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b00, 1'b0);
    repeat (10) step();
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b01, 1'b0);
    repeat (100) step();
    checkOutput("mode_busy", 32'(busy_cycles), 32'd84);
    checkOutput("mode_dones", 32'(done_seen), 32'd2);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      i_reset = ($urandom_range(0, 299) == 0);
      applyStimulus($urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 9) != 0,
                    2'($urandom), 1'($urandom));
      step();
    end
    i_reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b00, 1'b0);
    repeat (260) step();
    checkOutput("final_empty", 32'(o_fifo_empty), 32'd1);
    checkOutput("final_idle", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
